mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 64x8 CPU memory between two requesters: the CPU datapath (fetch/operand
//  reads) and a host/loader port (program load, debug peek/poke). Sits between the control
//  unit/register block and the memory. It serialises accesses, applies a fixed access latency
//  and returns per-requester acknowledge and read data. Round-robin arbitration on contention.
// PARAMETERS
//  AW       6  address width (64-word memory)
//  DW       8  data width
//  MEM_LAT  1  cycles mem_read/mem_write held per access; legal range 1..15
// PORTS
//  clk         in   1   clock; all state changes on posedge
//  reset       in   1   synchronous, active-high reset
//  cpu_req     in   1   CPU access request; held high until cpu_ack
//  cpu_we      in   1   1=write, 0=read; valid while cpu_req
//  cpu_addr    in   AW  CPU address
//  cpu_wdata   in   DW  CPU write data
//  cpu_ack     out  1   one-cycle completion pulse to CPU
//  cpu_rdata   out  DW  CPU read data; valid with cpu_ack, held until next CPU read ack
//  host_req    in   1   host access request; held high until host_ack
//  host_we     in   1   1=write, 0=read
//  host_addr   in   AW  host address
//  host_wdata  in   DW  host write data
//  host_ack    out  1   one-cycle completion pulse to host
//  host_rdata  out  DW  host read data; valid with host_ack, held until next host read ack
//  mem_read    out  1   memory read strobe
//  mem_write   out  1   memory write strobe
//  mem_a       out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data (combinational from mem_a while mem_read)
//  busy        out  1   1 in ACCESS or ACK
//  owner       out  1   0=CPU, 1=host; granted requester of current/last access
// BEHAVIOUR
//  - States: IDLE -> ACCESS -> ACK -> IDLE. All outputs registered or decoded from state regs.
//  - Reset (sync, priority over everything): state=IDLE, all strobes/acks=0, mem_a=0,
//    mem_wdata=0, cpu_rdata=host_rdata=0, owner=0, busy=0, last_grant=host (CPU wins first tie).
//  - IDLE: sample reqs each edge. One req high -> grant it. Both high -> grant requester that
//    is NOT last_grant; update last_grant. Latch winner's we/addr/wdata; load lat_cnt=MEM_LAT-1;
//    go ACCESS. No req -> stay IDLE.
//  - ACCESS: mem_a/mem_wdata from latched regs; mem_read=~we for all MEM_LAT cycles; mem_write=we
//    only in the final ACCESS cycle (lat_cnt==0), so memory commits exactly once. lat_cnt
//    decrements each cycle; at lat_cnt==0 a read captures mem_rdata into winner's rdata reg; go ACK.
//  - ACK: winner's ack=1 for exactly one cycle; strobes low; go IDLE. Loser's req ignored until IDLE.
//  - Latency: request seen in IDLE at edge N -> ack high in cycle N+MEM_LAT+1. Max throughput one
//    access per MEM_LAT+2 cycles. Requester that drops req after ack is clear; req still high in
//    the IDLE cycle after ack is a new request.
//  - Req dropped mid-access: transaction completes on latched values; ack still pulses.
//  - Input changes on addr/we/wdata after grant have no effect on the in-flight access.
//  - Reset during ACCESS/ACK: abort, no ack issued; a write whose final ACCESS cycle coincides
//    with the reset edge is committed by memory (memory is not reset).
//  - Write access: rdata regs unchanged. Never mem_read and mem_write high together.
// TESTING
//  1 Reset: reset=1 two cycles -> all outputs 0, owner=0, busy=0; release, no req -> stays IDLE.
//  2 CPU read, MEM_LAT=1: mem[0x05]=0xA3, cpu_req addr=0x05 -> mem_read 1 cycle, cpu_ack 2
//    cycles after grant edge, cpu_rdata=0xA3 and held after req drops.
//  3 Host write then CPU read: host writes 0x3C to 0x3F -> host_ack; CPU reads 0x3F -> 0x3C.
//  4 Contention: both req every cycle, 6 accesses -> grants CPU,host,CPU,host,CPU,host; no double ack.
//  5 MEM_LAT=3: host read 0x10 -> mem_read high 3 cycles, mem_write 0, ack 4 cycles after grant.
//  6 Reset mid-ACCESS (MEM_LAT=3, cycle 2): no ack, state IDLE, next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter between the CPU and the host for a single shared memory with a fixed access latency
module mem_port_arbiter #(
   parameter int AW      = 6,
   parameter int DW      = 8,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);
   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
   state_t        state;
   logic          last_grant;
   logic          we_q;
   logic [3:0]    lat_cnt;
   logic          grant_host;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   // pick the winner: a lone requester wins, on a tie the one not served last wins
   always_comb begin
      grant_host = host_req & (~cpu_req | ~last_grant);
      sel_we     = grant_host ? host_we : cpu_we;
      sel_addr   = grant_host ? host_addr : cpu_addr;
      sel_wdata  = grant_host ? host_wdata : cpu_wdata;
   end
   // access sequencer; the write strobe is raised only for the last access cycle so memory commits once
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         busy       <= 1'b0;
         we_q       <= 1'b0;
         lat_cnt    <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_a      <= '0;
         mem_wdata  <= '0;
         cpu_ack    <= 1'b0;
         host_ack   <= 1'b0;
         cpu_rdata  <= '0;
         host_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req | host_req) begin
                  state      <= ACCESS;
                  busy       <= 1'b1;
                  owner      <= grant_host;
                  last_grant <= grant_host;
                  we_q       <= sel_we;
                  mem_a      <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_read   <= ~sel_we;
                  mem_write  <= sel_we && (MEM_LAT == 1);
                  lat_cnt    <= 4'(MEM_LAT - 1);
               end
            end
            ACCESS: begin
               if (lat_cnt == 4'd0) begin
                  state     <= ACK;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  cpu_ack   <= ~owner;
                  host_ack  <= owner;
                  if (!we_q && owner) host_rdata <= mem_rdata;
                  if (!we_q && !owner) cpu_rdata <= mem_rdata;
               end else begin
                  lat_cnt   <= lat_cnt - 4'd1;
                  mem_write <= we_q && (lat_cnt == 4'd1);
               end
            end
            ACK: begin
               state    <= IDLE;
               busy     <= 1'b0;
               cpu_ack  <= 1'b0;
               host_ack <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter, instance 0 with MEM_LAT=1 and instance 1 with MEM_LAT=3
module tb_mem_port_arbiter;
   logic       clk = 1'b0;
   logic       reset [2];
   logic       cpu_req [2], cpu_we [2], host_req [2], host_we [2];
   logic [5:0] cpu_addr [2], host_addr [2], mem_a [2];
   logic [7:0] cpu_wdata [2], host_wdata [2], cpu_rdata [2], host_rdata [2], mem_wdata [2], mem_rdata [2];
   logic       cpu_ack [2], host_ack [2], mem_read [2], mem_write [2], busy [2], owner [2];
   logic [7:0] mem [2][64];
   logic [7:0] ref_mem [2][64];
   logic       pl_en;
   logic [5:0] pl_a;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(.AW(6), .DW(8), .MEM_LAT(g == 0 ? 1 : 3)) dut (
         .clk(clk), .reset(reset[g]),
         .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
         .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
         .host_req(host_req[g]), .host_we(host_we[g]), .host_addr(host_addr[g]), .host_wdata(host_wdata[g]),
         .host_ack(host_ack[g]), .host_rdata(host_rdata[g]),
         .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_a(mem_a[g]), .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g]));
   end

   // memories behind the two arbiters, preloaded from the reference image
   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (mem_write[k]) mem[k][mem_a[k]] <= mem_wdata[k];
         else if (pl_en) mem[k][pl_a] <= ref_mem[k][pl_a];

   always_comb
      for (int k = 0; k < 2; k++) mem_rdata[k] = mem[k][mem_a[k]];

   task automatic idle_inputs(input int k);
      cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = 0; cpu_wdata[k] = 0;
      host_req[k] = 0; host_we[k] = 0; host_addr[k] = 0; host_wdata[k] = 0;
   endtask

   task automatic do_reset(input int k);
      idle_inputs(k);
      reset[k] = 1;
      repeat (2) @(negedge clk);
      reset[k] = 0;
   endtask

   task automatic test_reset();
      reset[0] = 1; reset[1] = 1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({cpu_ack[k], host_ack[k], mem_read[k], mem_write[k], busy[k], owner[k], mem_a[k], mem_wdata[k],
              cpu_rdata[k], host_rdata[k]} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs inst%0d: got ack=%b%b rd=%b wr=%b busy=%b own=%b a=%h wd=%h crd=%h hrd=%h, want all 0",
                     k, cpu_ack[k], host_ack[k], mem_read[k], mem_write[k], busy[k], owner[k], mem_a[k],
                     mem_wdata[k], cpu_rdata[k], host_rdata[k]);
         end
      end
      reset[0] = 0; reset[1] = 0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({cpu_ack[k], host_ack[k], mem_read[k], mem_write[k], busy[k], owner[k]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle inst%0d: got ack=%b%b rd=%b wr=%b busy=%b own=%b, want all 0",
                     k, cpu_ack[k], host_ack[k], mem_read[k], mem_write[k], busy[k], owner[k]);
         end
      end
   endtask

   task automatic test_cpu_read();
      cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 6'h05;
      @(negedge clk);
      checks++;
      if ({mem_read[0], mem_write[0], mem_a[0], cpu_ack[0], busy[0], owner[0]} !== {2'b10, 6'h05, 3'b010}) begin
         errors++;
         $display("FAIL cpu_read_access: got rd=%b wr=%b a=%h ack=%b busy=%b own=%b, want rd=1 wr=0 a=05 ack=0 busy=1 own=0",
                  mem_read[0], mem_write[0], mem_a[0], cpu_ack[0], busy[0], owner[0]);
      end
      cpu_addr[0] = 6'h2A;
      @(negedge clk);
      checks++;
      if ({cpu_ack[0], host_ack[0], mem_read[0], cpu_rdata[0]} !== {3'b100, 8'hA3}) begin
         errors++;
         $display("FAIL cpu_read_ack: got ack=%b hack=%b rd=%b rdata=%h, want ack=1 hack=0 rd=0 rdata=a3",
                  cpu_ack[0], host_ack[0], mem_read[0], cpu_rdata[0]);
      end
      cpu_req[0] = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cpu_ack[0], busy[0], cpu_rdata[0]} !== {2'b00, 8'hA3}) begin
         errors++;
         $display("FAIL cpu_read_hold: got ack=%b busy=%b rdata=%h, want ack=0 busy=0 rdata=a3",
                  cpu_ack[0], busy[0], cpu_rdata[0]);
      end
   endtask

   task automatic test_host_write_cpu_read();
      host_req[0] = 1; host_we[0] = 1; host_addr[0] = 6'h3F; host_wdata[0] = 8'h3C;
      @(negedge clk);
      checks++;
      if ({mem_write[0], mem_read[0], mem_a[0], mem_wdata[0], owner[0]} !== {2'b10, 6'h3F, 8'h3C, 1'b1}) begin
         errors++;
         $display("FAIL host_write_access: got wr=%b rd=%b a=%h wd=%h own=%b, want wr=1 rd=0 a=3f wd=3c own=1",
                  mem_write[0], mem_read[0], mem_a[0], mem_wdata[0], owner[0]);
      end
      host_wdata[0] = 8'hFF;
      @(negedge clk);
      checks++;
      if ({host_ack[0], cpu_ack[0], host_rdata[0]} !== {2'b10, 8'h00}) begin
         errors++;
         $display("FAIL host_write_ack: got hack=%b cack=%b hrdata=%h, want hack=1 cack=0 hrdata=00",
                  host_ack[0], cpu_ack[0], host_rdata[0]);
      end
      ref_mem[0][63] = 8'h3C;
      host_req[0] = 0;
      @(negedge clk);
      cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 6'h3F;
      repeat (2) @(negedge clk);
      checks++;
      if ({cpu_ack[0], cpu_rdata[0]} !== {1'b1, 8'h3C}) begin
         errors++;
         $display("FAIL cpu_read_back: got ack=%b rdata=%h, want ack=1 rdata=3c", cpu_ack[0], cpu_rdata[0]);
      end
      cpu_req[0] = 0;
      @(negedge clk);
   endtask

   task automatic test_contention();
      logic [1:0] want;
      int         who;
      do_reset(0);
      cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 6'h01;
      host_req[0] = 1; host_we[0] = 0; host_addr[0] = 6'h02;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         who  = (i / 3) % 2;
         want = (i % 3 == 1) ? (who == 1 ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if ({cpu_ack[0], host_ack[0]} !== want) begin
            errors++;
            $display("FAIL contention_ack slot%0d: got cack,hack=%b, want %b", i, {cpu_ack[0], host_ack[0]}, want);
         end
         if (want != 2'b00) begin
            checks++;
            if ((who == 1 ? host_rdata[0] : cpu_rdata[0]) !== ref_mem[0][who == 1 ? 2 : 1]) begin
               errors++;
               $display("FAIL contention_rdata slot%0d: got %h, want %h", i,
                        who == 1 ? host_rdata[0] : cpu_rdata[0], ref_mem[0][who == 1 ? 2 : 1]);
            end
         end
      end
      idle_inputs(0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_lat3_host_read();
      host_req[1] = 1; host_we[1] = 0; host_addr[1] = 6'h10;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         checks++;
         if ({mem_read[1], mem_write[1], host_ack[1], mem_a[1]} !== {3'b100, 6'h10}) begin
            errors++;
            $display("FAIL lat3_access cycle%0d: got rd=%b wr=%b ack=%b a=%h, want rd=1 wr=0 ack=0 a=10",
                     j, mem_read[1], mem_write[1], host_ack[1], mem_a[1]);
         end
         @(negedge clk);
      end
      checks++;
      if ({host_ack[1], mem_read[1], host_rdata[1]} !== {2'b10, ref_mem[1][16]}) begin
         errors++;
         $display("FAIL lat3_ack: got ack=%b rd=%b rdata=%h, want ack=1 rd=0 rdata=%h",
                  host_ack[1], mem_read[1], host_rdata[1], ref_mem[1][16]);
      end
      host_req[1] = 0;
      @(negedge clk);
      checks++;
      if ({host_ack[1], mem_read[1]} !== 2'b00) begin
         errors++;
         $display("FAIL lat3_after: got ack=%b rd=%b, want 0 0", host_ack[1], mem_read[1]);
      end
   endtask

   task automatic test_reset_mid_access();
      cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 6'h20;
      repeat (2) @(negedge clk);
      reset[1] = 1; cpu_req[1] = 0;
      @(negedge clk);
      checks++;
      if ({cpu_ack[1], host_ack[1], mem_read[1], mem_write[1], busy[1], owner[1], mem_a[1], mem_wdata[1],
           cpu_rdata[1], host_rdata[1]} !== 36'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got ack=%b%b rd=%b wr=%b busy=%b own=%b a=%h wd=%h crd=%h hrd=%h, want all 0",
                  cpu_ack[1], host_ack[1], mem_read[1], mem_write[1], busy[1], owner[1], mem_a[1],
                  mem_wdata[1], cpu_rdata[1], host_rdata[1]);
      end
      reset[1] = 0;
      host_req[1] = 1; host_we[1] = 0; host_addr[1] = 6'h21;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         checks++;
         if ({cpu_ack[1], host_ack[1], owner[1]} !== {1'b0, j == 3, 1'b1}) begin
            errors++;
            $display("FAIL midreset_next cycle%0d: got cack=%b hack=%b own=%b, want 0 %0d 1",
                     j, cpu_ack[1], host_ack[1], owner[1], j == 3);
         end
         if (j == 3) begin
            checks++;
            if (host_rdata[1] !== ref_mem[1][33]) begin
               errors++;
               $display("FAIL midreset_rdata: got %h, want %h", host_rdata[1], ref_mem[1][33]);
            end
            host_req[1] = 0;
         end
      end
   endtask

   task automatic test_random(input int k, input int lat, input int n);
      logic       rq [2], rwe [2], rdp [2];
      logic [5:0] ra [2];
      logic [7:0] rd [2], exp_rd [2], held [2];
      int         st [2], ack_at [2];
      int         free_at, gedge, lastg, own_exp, w, bad;
      logic       a [2], busy_exp;
      do_reset(k);
      for (int r = 0; r < 2; r++) begin
         rq[r] = 0; rwe[r] = 0; ra[r] = 0; rd[r] = 0; rdp[r] = 0;
         exp_rd[r] = 0; held[r] = 0; st[r] = 0; ack_at[r] = -1;
      end
      free_at = 1; gedge = -100; lastg = 1; own_exp = 0;
      for (int e = 1; e <= n; e++) begin
         @(negedge clk);
         for (int r = 0; r < 2; r++) begin
            a[r] = (st[r] == 2) && (ack_at[r] == e);
            if (a[r] && rdp[r]) held[r] = exp_rd[r];
         end
         busy_exp = (e >= gedge) && (e <= gedge + lat);
         checks++;
         if ({cpu_ack[k], host_ack[k], busy[k], owner[k]} !== {a[0], a[1], busy_exp, own_exp[0]}) begin
            errors++;
            $display("FAIL rand%0d_ctrl e=%0d: got cack=%b hack=%b busy=%b own=%b, want %b %b %b %0d",
                     k, e, cpu_ack[k], host_ack[k], busy[k], owner[k], a[0], a[1], busy_exp, own_exp);
         end
         checks++;
         if ({cpu_rdata[k], host_rdata[k], mem_read[k] & mem_write[k]} !== {held[0], held[1], 1'b0}) begin
            errors++;
            $display("FAIL rand%0d_data e=%0d: got crd=%h hrd=%h rd&wr=%b, want %h %h 0",
                     k, e, cpu_rdata[k], host_rdata[k], mem_read[k] & mem_write[k], held[0], held[1]);
         end
         for (int r = 0; r < 2; r++) begin
            if (a[r]) begin
               st[r] = 0; rq[r] = 0;
            end
            if (st[r] == 2) begin
               rwe[r] = 1'($urandom); ra[r] = 6'($urandom); rd[r] = 8'($urandom);
               if ($urandom_range(3) == 0) rq[r] = 0;
            end
            if (st[r] == 0 && e < n - 20 && $urandom_range(2) != 0) begin
               st[r] = 1; rq[r] = 1; rwe[r] = 1'($urandom);
               ra[r] = 6'($urandom_range(15)); rd[r] = 8'($urandom);
            end
         end
         cpu_req[k] = rq[0]; cpu_we[k] = rwe[0]; cpu_addr[k] = ra[0]; cpu_wdata[k] = rd[0];
         host_req[k] = rq[1]; host_we[k] = rwe[1]; host_addr[k] = ra[1]; host_wdata[k] = rd[1];
         if (e + 1 >= free_at && (st[0] == 1 || st[1] == 1)) begin
            w = (st[0] == 1 && st[1] == 1) ? 1 - lastg : (st[1] == 1 ? 1 : 0);
            lastg = w; own_exp = w; gedge = e + 1;
            free_at = e + 1 + lat + 2; ack_at[w] = e + 1 + lat; st[w] = 2;
            rdp[w] = !rwe[w];
            if (rwe[w]) ref_mem[k][ra[w]] = rd[w];
            else exp_rd[w] = ref_mem[k][ra[w]];
         end
      end
      idle_inputs(k);
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem[k][i] !== ref_mem[k][i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rand%0d_memory: got %0d differing words, want 0", k, bad);
      end
   endtask

   initial begin
      reset[0] = 1; reset[1] = 1;
      idle_inputs(0); idle_inputs(1);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) ref_mem[k][i] = 8'($urandom);
      ref_mem[0][5] = 8'hA3;
      pl_en = 1;
      for (int i = 0; i < 64; i++) begin
         pl_a = 6'(i);
         @(negedge clk);
      end
      pl_en = 0;
      test_reset();
      test_cpu_read();
      test_host_write_cpu_read();
      test_contention();
      test_lat3_host_read();
      test_reset_mid_access();
      test_random(0, 1, 400);
      test_random(1, 3, 400);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
